// File: rtl/uigr_pkg.sv
// Shared types and constants for the in-game-reset sequencer.
package uigr_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ASSERT  = 3'd1,
    ST_GAP     = 3'd2,
    ST_HOLD    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  // Sequence request modes.
  localparam logic [1:0] MODE_SHORT = 2'd0;
  localparam logic [1:0] MODE_LONG  = 2'd1;
  localparam logic [1:0] MODE_BURST = 2'd2;
  localparam logic [1:0] MODE_HOLD  = 2'd3;

  // Default tick counts for a 50 MHz system clock.
  localparam int DEFAULT_SHORT_TICKS   = 10_000_000;   // 200 ms
  localparam int DEFAULT_LONG_TICKS    = 450_000_000;  // 9 s
  localparam int DEFAULT_GAP_TICKS     = 5_000_000;    // 100 ms
  localparam int DEFAULT_HOLDOFF_TICKS = 25_000_000;   // 500 ms

  // True when a non-negative tick count is representable in a counter of width w.
  function automatic bit ticks_fit(input longint value, input int w);
    if (w >= 63) return 1'b1;
    return value < (longint'(1) << w);
  endfunction

endpackage

// File: rtl/uigr_tick_timer.sv
// Loadable down-counter; holds at zero and flags expiry while at zero.
module uigr_tick_timer #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [COUNT_W-1:0] load_value_i,
  output logic [COUNT_W-1:0] value_o,
  output logic               expired_o
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  // Load takes priority; otherwise count down and saturate at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - COUNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign value_o   = count_q;
  assign expired_o = (count_q == '0);

endmodule

// File: rtl/uigr_reset_sequencer.sv
// Console reset-line sequencer: short, long, burst or operator-held pulses,
// followed by an optional holdoff, with abort and a completion strobe.
module uigr_reset_sequencer
  import uigr_pkg::*;
#(
  parameter int SHORT_TICKS   = DEFAULT_SHORT_TICKS,
  parameter int LONG_TICKS    = DEFAULT_LONG_TICKS,
  parameter int GAP_TICKS     = DEFAULT_GAP_TICKS,
  parameter int HOLDOFF_TICKS = DEFAULT_HOLDOFF_TICKS,
  parameter int COUNT_W       = 32,
  parameter int PULSE_W       = 4,
  parameter bit OUT_INVERT    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [PULSE_W-1:0] pulses,
  output logic               out,
  output logic               busy,
  output logic               done
);

  // Parameter sanity, rejected at elaboration.
  if (SHORT_TICKS < 1) begin : g_bad_short
    $error("SHORT_TICKS must be at least 1");
  end
  if (LONG_TICKS < 1) begin : g_bad_long
    $error("LONG_TICKS must be at least 1");
  end
  if (GAP_TICKS < 1) begin : g_bad_gap
    $error("GAP_TICKS must be at least 1");
  end
  if (HOLDOFF_TICKS < 0) begin : g_bad_holdoff
    $error("HOLDOFF_TICKS must not be negative");
  end
  if (COUNT_W < 1 || PULSE_W < 1) begin : g_bad_width
    $error("COUNT_W and PULSE_W must be at least 1");
  end
  if (!ticks_fit(longint'(SHORT_TICKS), COUNT_W) || !ticks_fit(longint'(LONG_TICKS), COUNT_W) ||
      !ticks_fit(longint'(GAP_TICKS), COUNT_W) || !ticks_fit(longint'(HOLDOFF_TICKS), COUNT_W))
  begin : g_bad_fit
    $error("a tick count does not fit in COUNT_W bits");
  end

  // Timer reload values: load T-1 and expire at zero so each phase lasts T cycles.
  localparam logic [COUNT_W-1:0] SHORT_LOAD   = COUNT_W'(SHORT_TICKS - 1);
  localparam logic [COUNT_W-1:0] LONG_LOAD    = COUNT_W'(LONG_TICKS - 1);
  localparam logic [COUNT_W-1:0] GAP_LOAD     = COUNT_W'(GAP_TICKS - 1);
  localparam logic [COUNT_W-1:0] HOLDOFF_LOAD =
    (HOLDOFF_TICKS > 0) ? COUNT_W'(HOLDOFF_TICKS - 1) : '0;
  localparam bit HAS_HOLDOFF = (HOLDOFF_TICKS > 0);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [PULSE_W-1:0] remain_q, remain_d;
  logic               out_q, out_d;
  logic               done_q, done_d;

  logic               tmr_load;
  logic [COUNT_W-1:0] tmr_load_val;
  logic [COUNT_W-1:0] tmr_value_unused;
  logic               tmr_expired;

  uigr_tick_timer #(
    .COUNT_W (COUNT_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .load_i       (tmr_load),
    .load_value_i (tmr_load_val),
    .value_o      (tmr_value_unused),
    .expired_o    (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, timer reloads and request latching.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    remain_d     = remain_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d       = mode;
          // remain counts pulses still to come after the current one; 0 pulses acts as 1.
          remain_d     = (pulses == '0) ? '0 : pulses - PULSE_W'(1);
          state_d      = (mode == MODE_HOLD) ? ST_HOLD : ST_ASSERT;
          tmr_load     = 1'b1;
          tmr_load_val = (mode == MODE_LONG) ? LONG_LOAD : SHORT_LOAD;
        end
      end
      ST_ASSERT: begin
        if (tmr_expired) begin
          if (mode_q == MODE_BURST && remain_q != '0) begin
            state_d      = ST_GAP;
            tmr_load     = 1'b1;
            tmr_load_val = GAP_LOAD;
          end else begin
            state_d      = HAS_HOLDOFF ? ST_HOLDOFF : ST_IDLE;
            tmr_load     = HAS_HOLDOFF;
            tmr_load_val = HOLDOFF_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (tmr_expired) begin
          remain_d     = remain_q - PULSE_W'(1);
          state_d      = ST_ASSERT;
          tmr_load     = 1'b1;
          tmr_load_val = SHORT_LOAD;
        end
      end
      ST_HOLD: begin
        // Operator hold: stay while start is held, but never shorter than a short pulse.
        if (!start && tmr_expired) begin
          state_d      = HAS_HOLDOFF ? ST_HOLDOFF : ST_IDLE;
          tmr_load     = HAS_HOLDOFF;
          tmr_load_val = HOLDOFF_LOAD;
        end
      end
      ST_HOLDOFF: begin
        if (tmr_expired) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Abort wins over everything, including a start on the same edge.
    if (abort && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      tmr_load = 1'b0;
    end
  end

  // Output decode: out follows the next state so it can be driven from a flop.
  always_comb begin
    out_d  = ((state_d == ST_ASSERT) || (state_d == ST_HOLD)) ^ OUT_INVERT;
    done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE) && !abort;
    busy   = (state_q != ST_IDLE);
  end

  // Registered outputs and latched request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_SHORT;
      remain_q <= '0;
      out_q    <= OUT_INVERT;
      done_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      remain_q <= remain_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;

endmodule

// File: tb/tb_uigr_reset_sequencer.sv
// Directed bench: SHORT=4, LONG=10, GAP=3, HOLDOFF=5, plus an inverted-output twin.
module tb_uigr_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [1:0] mode;
  logic [3:0] pulses;
  logic       out_s, busy_s, done_s;
  logic       out_n, busy_n, done_n;

  int checks = 0;
  int errors = 0;

  uigr_reset_sequencer #(
    .SHORT_TICKS(4), .LONG_TICKS(10), .GAP_TICKS(3), .HOLDOFF_TICKS(5),
    .COUNT_W(16), .PULSE_W(4), .OUT_INVERT(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .pulses(pulses),
    .out(out_s), .busy(busy_s), .done(done_s)
  );

  uigr_reset_sequencer #(
    .SHORT_TICKS(4), .LONG_TICKS(10), .GAP_TICKS(3), .HOLDOFF_TICKS(5),
    .COUNT_W(16), .PULSE_W(4), .OUT_INVERT(1'b1)
  ) dut_inv (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .pulses(pulses),
    .out(out_n), .busy(busy_n), .done(done_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Checks n consecutive cycles; bit n-1 of each vector is the current cycle.
  task automatic seq(input string tag, input int n, input logic [31:0] eo,
                     input logic [31:0] eb, input logic [31:0] ed);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s out c%0d", tag, i), out_s, eo[n-1-i]);
      chk($sformatf("%s busy c%0d", tag, i), busy_s, eb[n-1-i]);
      chk($sformatf("%s done c%0d", tag, i), done_s, ed[n-1-i]);
      chk($sformatf("%s inv_out c%0d", tag, i), out_n, ~eo[n-1-i]);
      chk($sformatf("%s inv_busy c%0d", tag, i), busy_n, eb[n-1-i]);
      chk($sformatf("%s inv_done c%0d", tag, i), done_n, ed[n-1-i]);
      if (i < n - 1) tick();
    end
    $display("seq %s: %0d cycles checked", tag, n);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; pulses = 4'd0;
    #12;
    chk("rst out", out_s, 1'b0);
    chk("rst busy", busy_s, 1'b0);
    chk("rst done", done_s, 1'b0);
    chk("rst inv_out", out_n, 1'b1);
    rst = 1'b0;
    tick();
    chk("idle busy", busy_s, 1'b0);

    // Mode 0 short pulse: 4 high, 5 holdoff, done.
    mode = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    seq("short", 10, 32'b1111000000, 32'b1111111110, 32'b0000000001);

    // Burst of 3 with gaps of 3 and holdoff of 5.
    mode = 2'd2; pulses = 4'd3; start = 1'b1;
    tick();
    start = 1'b0; pulses = 4'd7;
    seq("burst3", 24, 32'hF1E3C0, 32'hFFFFFE, 32'h000001);

    // Burst with pulses=0 behaves as a single pulse.
    mode = 2'd2; pulses = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    seq("burst0", 10, 32'b1111000000, 32'b1111111110, 32'b0000000001);

    // Start held through holdoff, mode changed mid-sequence: short runs, then long starts after done.
    mode = 2'd0; start = 1'b1;
    tick();
    mode = 2'd1;
    seq("b2b_short", 11, 32'b11110000001, 32'b11111111101, 32'b00000000010);
    start = 1'b0; mode = 2'd2;
    tick();
    seq("b2b_long", 15, 32'b111111111000000, 32'b111111111111110, 32'b000000000000001);

    // Hold mode, start held 2 edges: minimum 4 cycles high.
    mode = 2'd3; start = 1'b1;
    tick();
    chk("hold2 out c0", out_s, 1'b1);
    tick();
    start = 1'b0;
    seq("hold2", 9, 32'b111000000, 32'b111111110, 32'b000000001);

    // Hold mode, start held 12 edges: 12 cycles high.
    mode = 2'd3; start = 1'b1;
    tick();
    chk("hold12 out c0", out_s, 1'b1);
    for (int i = 1; i < 12; i++) begin
      tick();
      chk($sformatf("hold12 out c%0d", i), out_s, 1'b1);
    end
    start = 1'b0;
    tick();
    seq("hold12_tail", 6, 32'b000000, 32'b111110, 32'b000001);

    // Abort at the 3rd cycle of a long pulse.
    mode = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort pre out", out_s, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort out", out_s, 1'b0);
    chk("abort busy", busy_s, 1'b0);
    chk("abort done", done_s, 1'b0);
    tick();
    chk("abort no_done", done_s, 1'b0);
    chk("abort idle", busy_s, 1'b0);

    // Start and abort together in ASSERT: abort wins.
    mode = 2'd0; start = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    chk("st_ab busy", busy_s, 1'b0);
    chk("st_ab out", out_s, 1'b0);
    start = 1'b0; abort = 1'b0;
    tick();
    chk("st_ab done", done_s, 1'b0);
    chk("st_ab idle", busy_s, 1'b0);

    // Abort in IDLE is ignored: start still accepted.
    mode = 2'd0; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_ab busy", busy_s, 1'b1);
    chk("idle_ab out", out_s, 1'b1);
    tick();
    abort = 1'b0;
    chk("idle_ab cancel busy", busy_s, 1'b0);
    chk("idle_ab cancel done", done_s, 1'b0);

    // Asynchronous reset in the middle of a burst pulse.
    mode = 2'd2; pulses = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("arst pre out", out_s, 1'b1);
    chk("arst pre inv_out", out_n, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst out", out_s, 1'b0);
    chk("arst busy", busy_s, 1'b0);
    chk("arst inv_out", out_n, 1'b1);
    chk("arst inv_busy", busy_n, 1'b0);
    #2;
    rst = 1'b0;
    tick();
    chk("arst after busy", busy_s, 1'b0);
    chk("arst after done", done_s, 1'b0);
    chk("arst after out", out_s, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uigr_reset_sequencer.md
# uigr_reset_sequencer

Parametrised successor to the single-shot in-game-reset driver. It generates reset-line patterns toward the console from one start request: short pulse, long pulse, burst of N short pulses, or operator-held reset. It adds a post-sequence holdoff, abort, a completion strobe and an output polarity option. The block sits between the controller-combo decoder and the console reset pin driver.

## Interface
- `SHORT_TICKS`, default 10_000_000: short pulse length in clk cycles (200 ms @ 50 MHz), ≥1.
- `LONG_TICKS`, default 450_000_000: long pulse length (9 s), ≥1.
- `GAP_TICKS`, default 5_000_000: deasserted gap between burst pulses, ≥1.
- `HOLDOFF_TICKS`, default 25_000_000: busy-but-idle time after the last pulse, ≥0.
- `COUNT_W`, default 32: tick counter width; every *_TICKS value must fit in it.
- `PULSE_W`, default 4: width of `pulses`.
- `OUT_INVERT`, default 0: 1 gives an active-low `out`.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: sequence request, level-sampled in IDLE.
- `abort` in 1: cancels any sequence.
- `mode` in 2: 0 short, 1 long, 2 burst, 3 hold.
- `pulses` in PULSE_W: burst pulse count (mode 2); 0 treated as 1.
- `out` out 1: reset drive, registered, `OUT_INVERT` applied.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle strobe on normal completion.

## Operation
- States: IDLE, ASSERT, GAP, HOLD, HOLDOFF.
- IDLE: `start`=1 at an edge latches `mode` and `pulses` (0→1), loads the timer and enters ASSERT (HOLD for mode 3). Later changes to mode/pulses are ignored until the next IDLE.
- ASSERT: `out` active for exactly SHORT_TICKS (modes 0, 2) or LONG_TICKS (mode 1). On expiry in mode 2 with remaining pulses >0: go to GAP. Otherwise go to HOLDOFF, or IDLE if HOLDOFF_TICKS=0.
- GAP: `out` inactive for GAP_TICKS, decrement remaining, then ASSERT.
- HOLD (mode 3): `out` active while `start`=1, minimum SHORT_TICKS. Leave when `start`=0 and the minimum has elapsed; go to HOLDOFF/IDLE as above.
- HOLDOFF: `out` inactive, `busy` high, `start` ignored, for HOLDOFF_TICKS. Then IDLE.
- `done` pulses for one cycle in the first IDLE cycle after a normal completion.
- `abort`=1 in any non-IDLE state: next state IDLE, `out` inactive next cycle, no `done`. Abort beats start on the same edge. Abort in IDLE has no effect.
- `start` held in IDLE during the `done` cycle is accepted (back-to-back sequences).
- Reset values: state IDLE, `out`=OUT_INVERT, `busy`=0, `done`=0, counters 0. Reset mid-sequence drops `out` immediately (asynchronously).

## Timing
- Start accepted at edge k: `out` and `busy` active from cycle k+1.
- Single pulse of length T: `out` active cycles k+1..k+T. `busy` active k+1..k+T+H. `done` at k+T+H+1.
- Burst of N: N×T active cycles, N−1 gaps of G cycles, then holdoff. Total busy = N·T+(N−1)·G+H.
- The timer loads T−1 and expires at 0, so there is no off-by-one: a pulse spans exactly T cycles.
- `out` comes straight from a flop; `busy` is decoded from registered state only.

## Structure
- Package `uigr_pkg`: state enum, mode constants (MODE_SHORT/LONG/BURST/HOLD), default tick constants for 50 MHz.
- Sub-module `uigr_tick_timer`: COUNT_W loadable down-counter with `load`, `value`, `expired` and async reset. The top level owns the FSM and pulse counter.
- Elaboration-time assertions: parameter ranges, and that every tick value fits in COUNT_W.

## Test plan
Bench parameters: SHORT=4, LONG=10, GAP=3, HOLDOFF=5, OUT_INVERT=0.
- Mode 0, start at k → `out`=1 on k+1..k+4; `busy` on k+1..k+9; `done` at k+10.
- Mode 2, pulses=3 → `out` pattern 1111 000 1111 000 1111, then 5 low busy cycles, then `done`. Pulses=0 gives a single pulse.
- Mode 3, start held 2 cycles → `out` high 4 cycles (minimum). Start held 12 cycles → `out` high 12 cycles.
- Abort at the 3rd cycle of a long pulse → `out` low next cycle, `busy` low, no `done`. Start+abort together in ASSERT → IDLE.
- Start held through HOLDOFF → ignored; new sequence begins the cycle after `done`. Mode changed mid-sequence has no effect.
- Async `rst` asserted mid-burst → `out`/`busy` low immediately. OUT_INVERT=1 run → `out` idle high, active low.
